rob: RTL and testbench
======================

ROB -- requirements
Module: rob

Interface
REQ-001 Parameter DEPTH, default 32, number of reorder-buffer entries; fixed at 32 to match the 5-bit index.
REQ-002 Parameter XLEN, default 32, width of PC, instruction and register value fields.
REQ-003 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_i  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 allocate_req_i  input  1  request to allocate one entry at the tail this cycle.
REQ-006 prd_addr_i  input  5  destination register address stored in the allocated entry.
REQ-007 pc_i  input  32  PC stored in the allocated entry.
REQ-008 inst_i  input  32  instruction word stored in the allocated entry.
REQ-009 update_req_alu_i, update_req_lsu_i, update_req_mul_i  input  1 each  writeback valid for the ALU, LSU and MUL ports.
REQ-010 rob_idx_alu_i, rob_idx_lsu_i, rob_idx_mul_i  input  32 each  target entry index; only bits [4:0] are used, upper bits ignored.
REQ-011 reg_value_alu_i, reg_value_lsu_i, reg_value_mul_i  input  32 each  result value for the targeted entry.
REQ-012 empty_o  output  1  high when no entries are occupied.
REQ-013 full_o  output  1  high when all 32 entries are occupied.
REQ-014 rob_idx_o  output  5  index of the current tail, i.e. the index an allocation this cycle receives.
REQ-015 commitment_valid_o  output  1  high when the head entry is occupied and ready.
REQ-016 inst_committed_o, pc_commited_o  output  32 each  instruction and PC of the head entry.
REQ-017 prd_addr_commited_o  output  5  destination address of the head entry.
REQ-018 prd_value_commited_o  output  32  result value of the head entry.

Function
REQ-019 Storage: circular buffer of 32 entries, each with valid, ready, prd_addr, pc, inst, value; head and tail pointers of 5 bits wrap 31->0; a 6-bit occupancy count 0..32.
REQ-020 empty_o = (count==0); full_o = (count==32); rob_idx_o = tail; all three combinational from registered state.
REQ-021 Allocation: when allocate_req_i=1 and full_o=0, at the clock edge the tail entry gets valid=1, ready=0, prd_addr/pc/inst from inputs, value=0, and tail increments modulo 32.
REQ-022 Allocation while full_o=1 is ignored with no state change, even if a commit occurs in the same cycle.
REQ-023 Update: for each asserted update port, if the indexed entry is valid, at the clock edge its value is written and ready set to 1; an update to an invalid entry is ignored.
REQ-024 Multiple ports targeting the same index in one cycle: priority ALU > LSU > MUL for the written value; distinct indices are all written in the same cycle.
REQ-025 An update never affects the entry being allocated in the same cycle; that entry ends with ready=0.
REQ-026 Commit: commitment_valid_o = valid[head] & ready[head] (combinational); commit outputs present the head entry fields; when commitment_valid_o=0 all commit data outputs are 0.
REQ-027 When commitment_valid_o=1, at the clock edge the head entry is cleared (valid=0, ready=0) and head increments modulo 32; at most one commit per cycle; commits are strictly in allocation order.
REQ-028 Count: +1 on allocation only, -1 on commit only, unchanged when both or neither occur.
REQ-029 An entry updated in cycle N is eligible for commit in cycle N+1 (no same-cycle bypass).
REQ-030 Out-of-order updates are allowed; a ready entry behind a non-ready head waits.

Reset
REQ-031 While reset_i=0, asynchronously: head=tail=count=0, all valid and ready bits 0, entry contents 0.
REQ-032 Reset outputs: empty_o=1, full_o=0, rob_idx_o=0, commitment_valid_o=0, all commit data outputs 0.
REQ-033 Reset asserted mid-operation discards all entries; pending requests in that cycle have no effect.

Verification
REQ-034 Reset then one allocation (prd 5, pc 0x100, inst 0x13) -> rob_idx_o 0 before edge, 1 after; empty_o=0; commitment_valid_o=0.
REQ-035 ALU update idx 0 value 0xAA -> next cycle commitment_valid_o=1 with pc 0x100, prd 5, value 0xAA; following cycle empty_o=1.
REQ-036 Allocate 3 entries, update idx 2 then idx 1 then idx 0 -> commits occur in order 0,1,2 on consecutive cycles only after idx 0 is ready.
REQ-037 32 allocations -> full_o=1, rob_idx_o=0; a 33rd request ignored; commit of head then allocation -> new entry at index 0 (wrap), full_o=1 again.
REQ-038 ALU and MUL update same idx same cycle with 0x11/0x22 -> committed value 0x11; update to an unallocated idx -> no commit, state unchanged.
REQ-039 Assert reset_i=0 with 4 occupied entries -> outputs immediately return to reset values without a clock edge.

Source files
------------

// File: rtl/rob.sv
// Reorder buffer: 32-entry circular queue. Entries are allocated at the tail,
// marked ready by three writeback ports (ALU/LSU/MUL) and retired in order
// from the head, at most one per cycle.
module rob #(
    parameter int DEPTH = 32,
    parameter int XLEN  = 32
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            allocate_req_i,
    input  logic [4:0]      prd_addr_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] inst_i,
    input  logic            update_req_alu_i,
    input  logic            update_req_lsu_i,
    input  logic            update_req_mul_i,
    input  logic [XLEN-1:0] rob_idx_alu_i,
    input  logic [XLEN-1:0] rob_idx_lsu_i,
    input  logic [XLEN-1:0] rob_idx_mul_i,
    input  logic [XLEN-1:0] reg_value_alu_i,
    input  logic [XLEN-1:0] reg_value_lsu_i,
    input  logic [XLEN-1:0] reg_value_mul_i,
    output logic            empty_o,
    output logic            full_o,
    output logic [4:0]      rob_idx_o,
    output logic            commitment_valid_o,
    output logic [XLEN-1:0] inst_committed_o,
    output logic [XLEN-1:0] pc_commited_o,
    output logic [4:0]      prd_addr_commited_o,
    output logic [XLEN-1:0] prd_value_commited_o
);

    localparam int IW = 5;

    logic [DEPTH-1:0]           valid_q;
    logic [DEPTH-1:0]           ready_q;
    logic [DEPTH-1:0][4:0]      prd_q;
    logic [DEPTH-1:0][XLEN-1:0] pc_q;
    logic [DEPTH-1:0][XLEN-1:0] inst_q;
    logic [DEPTH-1:0][XLEN-1:0] value_q;
    logic [IW-1:0]              head_q;
    logic [IW-1:0]              tail_q;
    logic [IW:0]                count_q;

    logic                       do_alloc;
    logic                       do_commit;
    logic [DEPTH-1:0]           upd_hit;
    logic [DEPTH-1:0][XLEN-1:0] upd_val;

    // Only the low index bits address the buffer; the rest is don't-care.
    logic unused_idx_bits;
    assign unused_idx_bits = ^{rob_idx_alu_i[XLEN-1:IW], rob_idx_lsu_i[XLEN-1:IW],
                               rob_idx_mul_i[XLEN-1:IW]};

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == (IW+1)'(DEPTH));
    assign rob_idx_o = tail_q;

    assign commitment_valid_o = valid_q[head_q] & ready_q[head_q];
    assign do_commit          = commitment_valid_o;
    // Allocation is refused whenever full, even if the head retires this cycle.
    assign do_alloc           = allocate_req_i & ~full_o;

    // Commit data is gated to zero unless the head can actually retire.
    always_comb begin
        inst_committed_o     = '0;
        pc_commited_o        = '0;
        prd_addr_commited_o  = '0;
        prd_value_commited_o = '0;
        if (commitment_valid_o) begin
            inst_committed_o     = inst_q[head_q];
            pc_commited_o        = pc_q[head_q];
            prd_addr_commited_o  = prd_q[head_q];
            prd_value_commited_o = value_q[head_q];
        end
    end

    // Per-entry writeback decode; ALU beats LSU beats MUL on a shared index.
    always_comb begin
        upd_hit = '0;
        upd_val = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i]) begin
                if (update_req_mul_i && rob_idx_mul_i[IW-1:0] == IW'(i)) begin
                    upd_hit[i] = 1'b1;
                    upd_val[i] = reg_value_mul_i;
                end
                if (update_req_lsu_i && rob_idx_lsu_i[IW-1:0] == IW'(i)) begin
                    upd_hit[i] = 1'b1;
                    upd_val[i] = reg_value_lsu_i;
                end
                if (update_req_alu_i && rob_idx_alu_i[IW-1:0] == IW'(i)) begin
                    upd_hit[i] = 1'b1;
                    upd_val[i] = reg_value_alu_i;
                end
            end
        end
    end

    // Entry state, pointers and occupancy; later assignments take precedence
    // (writeback, then retire, then allocate into the freshly chosen tail).
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            valid_q <= '0;
            ready_q <= '0;
            prd_q   <= '0;
            pc_q    <= '0;
            inst_q  <= '0;
            value_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (upd_hit[i]) begin
                    value_q[i] <= upd_val[i];
                    ready_q[i] <= 1'b1;
                end
            end
            if (do_commit) begin
                valid_q[head_q] <= 1'b0;
                ready_q[head_q] <= 1'b0;
                head_q          <= head_q + 1'b1;
            end
            if (do_alloc) begin
                valid_q[tail_q] <= 1'b1;
                ready_q[tail_q] <= 1'b0;
                prd_q[tail_q]   <= prd_addr_i;
                pc_q[tail_q]    <= pc_i;
                inst_q[tail_q]  <= inst_i;
                value_q[tail_q] <= '0;
                tail_q          <= tail_q + 1'b1;
            end
            case ({do_alloc, do_commit})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_rob.sv
// Directed bench for the reorder buffer: a vector table for the basic flow
// plus hand-written sequences for wrap-around/full and asynchronous reset.
module tb_rob;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        allocate_req_i;
    logic [4:0]  prd_addr_i;
    logic [31:0] pc_i, inst_i;
    logic        update_req_alu_i, update_req_lsu_i, update_req_mul_i;
    logic [31:0] rob_idx_alu_i, rob_idx_lsu_i, rob_idx_mul_i;
    logic [31:0] reg_value_alu_i, reg_value_lsu_i, reg_value_mul_i;
    logic        empty_o, full_o, commitment_valid_o;
    logic [4:0]  rob_idx_o, prd_addr_commited_o;
    logic [31:0] inst_committed_o, pc_commited_o, prd_value_commited_o;

    int n_chk = 0;
    int n_fail = 0;

    rob #(.DEPTH(32), .XLEN(32)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .allocate_req_i(allocate_req_i), .prd_addr_i(prd_addr_i),
        .pc_i(pc_i), .inst_i(inst_i),
        .update_req_alu_i(update_req_alu_i), .update_req_lsu_i(update_req_lsu_i),
        .update_req_mul_i(update_req_mul_i),
        .rob_idx_alu_i(rob_idx_alu_i), .rob_idx_lsu_i(rob_idx_lsu_i),
        .rob_idx_mul_i(rob_idx_mul_i),
        .reg_value_alu_i(reg_value_alu_i), .reg_value_lsu_i(reg_value_lsu_i),
        .reg_value_mul_i(reg_value_mul_i),
        .empty_o(empty_o), .full_o(full_o), .rob_idx_o(rob_idx_o),
        .commitment_valid_o(commitment_valid_o),
        .inst_committed_o(inst_committed_o), .pc_commited_o(pc_commited_o),
        .prd_addr_commited_o(prd_addr_commited_o),
        .prd_value_commited_o(prd_value_commited_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic        alloc;
        logic [4:0]  prd;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        ua;  logic [31:0] ia; logic [31:0] va;
        logic        ul;  logic [31:0] il; logic [31:0] vl;
        logic        um;  logic [31:0] im; logic [31:0] vm;
        logic        e_empty;
        logic        e_full;
        logic [4:0]  e_idx;
        logic        e_cv;
        logic [31:0] e_inst;
        logic [31:0] e_pc;
        logic [4:0]  e_prd;
        logic [31:0] e_val;
    } vec_t;

    vec_t vecs[25];

    function automatic vec_t mk(input logic alloc, input logic [4:0] prd,
                                input logic [31:0] pc, input logic [31:0] inst,
                                input logic ua, input logic [31:0] ia, input logic [31:0] va,
                                input logic ul, input logic [31:0] il, input logic [31:0] vl,
                                input logic um, input logic [31:0] im, input logic [31:0] vm,
                                input logic e_empty, input logic [4:0] e_idx, input logic e_cv,
                                input logic [31:0] e_inst, input logic [31:0] e_pc,
                                input logic [4:0] e_prd, input logic [31:0] e_val);
        vec_t v;
        v.alloc = alloc; v.prd = prd; v.pc = pc; v.inst = inst;
        v.ua = ua; v.ia = ia; v.va = va;
        v.ul = ul; v.il = il; v.vl = vl;
        v.um = um; v.im = im; v.vm = vm;
        v.e_empty = e_empty; v.e_full = 1'b0; v.e_idx = e_idx; v.e_cv = e_cv;
        v.e_inst = e_inst; v.e_pc = e_pc; v.e_prd = e_prd; v.e_val = e_val;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic idle();
        allocate_req_i = 0; prd_addr_i = 0; pc_i = 0; inst_i = 0;
        update_req_alu_i = 0; update_req_lsu_i = 0; update_req_mul_i = 0;
        rob_idx_alu_i = 0; rob_idx_lsu_i = 0; rob_idx_mul_i = 0;
        reg_value_alu_i = 0; reg_value_lsu_i = 0; reg_value_mul_i = 0;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        idle();
        reset_i = 0;
        tick();
        reset_i = 1;
    endtask

    task automatic alloc(input logic [4:0] prd, input logic [31:0] pc, input logic [31:0] inst);
        idle();
        allocate_req_i = 1; prd_addr_i = prd; pc_i = pc; inst_i = inst;
    endtask

    task automatic upd_alu(input logic [31:0] idx, input logic [31:0] val);
        idle();
        update_req_alu_i = 1; rob_idx_alu_i = idx; reg_value_alu_i = val;
    endtask

    task automatic check_all(input string tag, input logic e_empty, input logic e_full,
                             input logic [4:0] e_idx, input logic e_cv,
                             input logic [31:0] e_inst, input logic [31:0] e_pc,
                             input logic [4:0] e_prd, input logic [31:0] e_val);
        check({tag, ".empty"}, 32'(empty_o), 32'(e_empty));
        check({tag, ".full"},  32'(full_o),  32'(e_full));
        check({tag, ".idx"},   32'(rob_idx_o), 32'(e_idx));
        check({tag, ".cv"},    32'(commitment_valid_o), 32'(e_cv));
        check({tag, ".inst"},  inst_committed_o, e_inst);
        check({tag, ".pc"},    pc_commited_o, e_pc);
        check({tag, ".prd"},   32'(prd_addr_commited_o), 32'(e_prd));
        check({tag, ".val"},   prd_value_commited_o, e_val);
    endtask

    initial begin
        // Inputs on each row are applied for one cycle; expectations describe
        // the outputs during that cycle, i.e. before its clock edge.
        //            al prd pc      inst     ua ia            va     ul il  vl     um im  vm     emp idx cv inst   pc      prd val
        vecs[0]  = mk(1, 5, 32'h100, 32'h13, 0, 0,            0,     0, 0,  0,     0, 0,  0,     1, 0, 0, 0,     0,      0, 0);
        vecs[1]  = mk(0, 0, 0,       0,      1, 0,            32'hAA, 0, 0, 0,     0, 0,  0,     0, 1, 0, 0,     0,      0, 0);
        vecs[2]  = mk(0, 0, 0,       0,      0, 0,            0,     0, 0,  0,     0, 0,  0,     0, 1, 1, 32'h13, 32'h100, 5, 32'hAA);
        vecs[3]  = mk(0, 0, 0,       0,      0, 0,            0,     0, 0,  0,     0, 0,  0,     1, 1, 0, 0,     0,      0, 0);
        vecs[4]  = mk(1, 1, 32'h200, 32'h21, 0, 0,            0,     0, 0,  0,     0, 0,  0,     1, 1, 0, 0,     0,      0, 0);
        vecs[5]  = mk(1, 2, 32'h204, 32'h22, 0, 0,            0,     0, 0,  0,     0, 0,  0,     0, 2, 0, 0,     0,      0, 0);
        vecs[6]  = mk(1, 3, 32'h208, 32'h23, 0, 0,            0,     0, 0,  0,     0, 0,  0,     0, 3, 0, 0,     0,      0, 0);
        vecs[7]  = mk(0, 0, 0,       0,      1, 3,            32'h33, 0, 0, 0,     0, 0,  0,     0, 4, 0, 0,     0,      0, 0);
        vecs[8]  = mk(0, 0, 0,       0,      0, 0,            0,     1, 2,  32'h22, 0, 0, 0,     0, 4, 0, 0,     0,      0, 0);
        vecs[9]  = mk(0, 0, 0,       0,      0, 0,            0,     0, 0,  0,     1, 1,  32'h11, 0, 4, 0, 0,    0,      0, 0);
        vecs[10] = mk(0, 0, 0,       0,      0, 0,            0,     0, 0,  0,     0, 0,  0,     0, 4, 1, 32'h21, 32'h200, 1, 32'h11);
        vecs[11] = mk(0, 0, 0,       0,      0, 0,            0,     0, 0,  0,     0, 0,  0,     0, 4, 1, 32'h22, 32'h204, 2, 32'h22);
        vecs[12] = mk(0, 0, 0,       0,      0, 0,            0,     0, 0,  0,     0, 0,  0,     0, 4, 1, 32'h23, 32'h208, 3, 32'h33);
        vecs[13] = mk(0, 0, 0,       0,      0, 0,            0,     0, 0,  0,     0, 0,  0,     1, 4, 0, 0,     0,      0, 0);
        vecs[14] = mk(1, 7, 32'h300, 32'h37, 0, 0,            0,     0, 0,  0,     0, 0,  0,     1, 4, 0, 0,     0,      0, 0);
        // ALU (upper index bits set) and MUL hit entry 4; LSU hits empty entry 9.
        vecs[15] = mk(0, 0, 0,       0,      1, 32'hFFFFFFE4, 32'h11, 1, 9, 32'h99, 1, 4, 32'h22, 0, 5, 0, 0,   0,      0, 0);
        vecs[16] = mk(0, 0, 0,       0,      0, 0,            0,     0, 0,  0,     0, 0,  0,     0, 5, 1, 32'h37, 32'h300, 7, 32'h11);
        vecs[17] = mk(0, 0, 0,       0,      0, 0,            0,     1, 9,  32'h99, 0, 0, 0,     1, 5, 0, 0,     0,      0, 0);
        vecs[18] = mk(0, 0, 0,       0,      0, 0,            0,     0, 0,  0,     0, 0,  0,     1, 5, 0, 0,     0,      0, 0);
        // Update aimed at the entry being allocated in the same cycle.
        vecs[19] = mk(1, 8, 32'h400, 32'h48, 1, 5,            32'h55, 0, 0, 0,     0, 0,  0,     1, 5, 0, 0,     0,      0, 0);
        vecs[20] = mk(0, 0, 0,       0,      0, 0,            0,     0, 0,  0,     0, 0,  0,     0, 6, 0, 0,     0,      0, 0);
        vecs[21] = mk(0, 0, 0,       0,      0, 0,            0,     0, 0,  0,     0, 0,  0,     0, 6, 0, 0,     0,      0, 0);
        vecs[22] = mk(0, 0, 0,       0,      1, 5,            32'h66, 0, 0, 0,     0, 0,  0,     0, 6, 0, 0,     0,      0, 0);
        vecs[23] = mk(0, 0, 0,       0,      0, 0,            0,     0, 0,  0,     0, 0,  0,     0, 6, 1, 32'h48, 32'h400, 8, 32'h66);
        vecs[24] = mk(0, 0, 0,       0,      0, 0,            0,     0, 0,  0,     0, 0,  0,     1, 6, 0, 0,     0,      0, 0);

        // Reset values, checked while reset is still held.
        idle();
        reset_i = 0;
        #2;
        check_all("reset", 1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        reset_i = 1;

        foreach (vecs[i]) begin
            allocate_req_i = vecs[i].alloc; prd_addr_i = vecs[i].prd;
            pc_i = vecs[i].pc; inst_i = vecs[i].inst;
            update_req_alu_i = vecs[i].ua; rob_idx_alu_i = vecs[i].ia; reg_value_alu_i = vecs[i].va;
            update_req_lsu_i = vecs[i].ul; rob_idx_lsu_i = vecs[i].il; reg_value_lsu_i = vecs[i].vl;
            update_req_mul_i = vecs[i].um; rob_idx_mul_i = vecs[i].im; reg_value_mul_i = vecs[i].vm;
            check_all($sformatf("v%0d", i), vecs[i].e_empty, vecs[i].e_full, vecs[i].e_idx,
                      vecs[i].e_cv, vecs[i].e_inst, vecs[i].e_pc, vecs[i].e_prd, vecs[i].e_val);
            tick();
        end

        // Fill, overflow, wrap-around and in-order drain.
        do_reset();
        for (int k = 0; k < 32; k++) begin
            alloc(5'(k), 32'h1000 + 32'(k) * 4, 32'h100 + 32'(k));
            tick();
        end
        idle();
        check_all("full", 0, 1, 0, 0, 0, 0, 0, 0);
        alloc(5'd30, 32'hDEAD, 32'hDEAD);
        tick();
        idle();
        check_all("overflow", 0, 1, 0, 0, 0, 0, 0, 0);
        upd_alu(0, 32'h77);
        tick();
        // Head retires while an allocation is requested: allocation dropped.
        alloc(5'd31, 32'hBAD, 32'hBAD);
        check_all("head_ready", 0, 1, 0, 1, 32'h100, 32'h1000, 0, 32'h77);
        tick();
        idle();
        check_all("after_commit", 0, 0, 0, 0, 0, 0, 0, 0);
        alloc(5'd9, 32'hABC, 32'hCBA);
        tick();
        idle();
        check_all("wrap_alloc", 0, 1, 1, 0, 0, 0, 0, 0);
        upd_alu(0, 32'hC0);
        tick();
        for (int k = 31; k >= 2; k--) begin
            upd_alu(32'(k), 32'(k));
            tick();
        end
        idle();
        check("head_blocks.cv", 32'(commitment_valid_o), 32'd0);
        upd_alu(1, 1);
        tick();
        idle();
        for (int j = 0; j < 32; j++) begin
            int e;
            e = (j + 1) % 32;
            check($sformatf("drain%0d.cv", j), 32'(commitment_valid_o), 32'd1);
            check($sformatf("drain%0d.pc", j), pc_commited_o,
                  (e == 0) ? 32'hABC : 32'h1000 + 32'(e) * 4);
            check($sformatf("drain%0d.val", j), prd_value_commited_o,
                  (e == 0) ? 32'hC0 : 32'(e));
            tick();
        end
        check_all("drained", 1, 0, 1, 0, 0, 0, 0, 0);

        // Asynchronous reset with occupied entries.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            alloc(5'(k + 1), 32'h2000 + 32'(k), 32'h50 + 32'(k));
            tick();
        end
        upd_alu(0, 32'h1);
        tick();
        idle();
        check_all("pre_rst", 0, 0, 4, 1, 32'h50, 32'h2000, 1, 32'h1);
        #2;
        reset_i = 0;
        #1;
        check_all("async_rst", 1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        reset_i = 1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
